pll_reset_sequencer: RTL and testbench

//  Power-up and lock supervisor for the system PLL. Runs on the free-running 50 MHz board clock,

---
 rtl/pll_reset_sequencer.sv | 109 ++++++++++
 tb/tb_pll_reset_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// PLL power-up/lock supervisor: pulses pll_rst, waits for a synchronised and
// continuously stable lock, then releases sys_rst. Retries on timeout, re-sequences on loss.
module pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES = 50,
  parameter int LOCK_TIMEOUT   = 50000,
  parameter int STABLE_CYCLES  = 1000,
  parameter int CNT_W          = 8
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             pll_locked,
  output logic             pll_rst,
  output logic             sys_rst,
  output logic             ready,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] retry_count,
  output logic [CNT_W-1:0] loss_count
);

  localparam int MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_C = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
  localparam int CW    = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] C_POR = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] C_TMO = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] C_STB = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    POR_HOLD  = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          r_sync1;
  logic          r_locked_s;
  logic          w_retry_inc;
  logic          w_loss_inc;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1    <= 1'b0;
      r_locked_s <= 1'b0;
    end else begin
      r_sync1    <= pll_locked;
      r_locked_s <= r_sync1;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_retry_inc = 1'b0;
    w_loss_inc  = 1'b0;
    case (r_state)
      POR_HOLD: begin
        if (r_cnt == C_POR) w_next = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // lock takes priority over a coincident timeout
        if (r_locked_s) begin
          w_next = STABLE;
        end else if (r_cnt == C_TMO) begin
          w_next      = POR_HOLD;
          w_retry_inc = 1'b1;
        end
      end
      STABLE: begin
        if (!r_locked_s)         w_next = WAIT_LOCK;
        else if (r_cnt == C_STB) w_next = RUN;
      end
      RUN: begin
        if (!r_locked_s) begin
          w_next     = POR_HOLD;
          w_loss_inc = 1'b1;
        end
      end
      default: w_next = POR_HOLD;
    endcase
    // counter parks at zero in RUN so it can never wrap
    w_cnt_next = ((w_next != r_state) || (r_state == RUN)) ? '0 : r_cnt + 1'b1;
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= POR_HOLD;
      r_cnt       <= '0;
      pll_rst     <= 1'b1;
      sys_rst     <= 1'b1;
      ready       <= 1'b0;
      retry_count <= '0;
      loss_count  <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      pll_rst <= (w_next == POR_HOLD);
      sys_rst <= (w_next != RUN);
      ready   <= (w_next == RUN);
      if (w_retry_inc && (retry_count != '1)) retry_count <= retry_count + 1'b1;
      if (w_loss_inc && (loss_count != '1))   loss_count  <= loss_count + 1'b1;
    end
  end

  assign state_o = r_state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench: timestamp-based behavioural model compared every cycle,
// plus directed scenarios with hand-derived literal expectations.
module tb_pll_reset_sequencer;

  localparam int P   = 4;
  localparam int T   = 20;
  localparam int S   = 8;
  localparam int CW  = 2;
  localparam int SAT = (1 << CW) - 1;

  logic          refclk;
  logic          rst_n;
  logic          pll_locked;
  logic          pll_rst;
  logic          sys_rst;
  logic          ready;
  logic [1:0]    state_o;
  logic [CW-1:0] retry_count;
  logic [CW-1:0] loss_count;

  int checks   = 0;
  int failures = 0;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES(P),
    .LOCK_TIMEOUT  (T),
    .STABLE_CYCLES (S),
    .CNT_W         (CW)
  ) dut (
    .refclk     (refclk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .pll_rst    (pll_rst),
    .sys_rst    (sys_rst),
    .ready      (ready),
    .state_o    (state_o),
    .retry_count(retry_count),
    .loss_count (loss_count)
  );

  initial refclk = 1'b0;
  always #10 refclk = ~refclk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: phase plus entry timestamp; time-in-phase = cycle - entry.
  int m_ph, m_t0, m_cyc, m_retry, m_loss;
  bit m_s1, m_s2;

  task automatic m_go(input int ph);
    m_ph = ph;
    m_t0 = m_cyc + 1;
  endtask

  always @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph = 0; m_t0 = 0; m_cyc = 0; m_retry = 0; m_loss = 0;
      m_s1 = 0; m_s2 = 0;
    end else begin
      bit ls;
      int el;
      ls   = m_s2;
      m_s2 = m_s1;
      m_s1 = pll_locked;
      el   = m_cyc - m_t0;
      case (m_ph)
        0: if (el == P - 1) m_go(1);
        1: if (ls) m_go(2);
           else if (el == T - 1) begin
             m_go(0);
             if (m_retry < SAT) m_retry++;
           end
        2: if (!ls) m_go(1);
           else if (el == S - 1) m_go(3);
        default: if (!ls) begin
             m_go(0);
             if (m_loss < SAT) m_loss++;
           end
      endcase
      m_cyc++;
    end
  end

  always @(negedge refclk) begin
    check("pll_rst", pll_rst, (m_ph == 0) ? 1 : 0);
    check("sys_rst", sys_rst, (m_ph != 3) ? 1 : 0);
    check("ready",   ready,   (m_ph == 3) ? 1 : 0);
    check("state_o", state_o, m_ph);
    check("retry_count", retry_count, m_retry);
    check("loss_count",  loss_count,  m_loss);
  end

  // Assert rst_n between edges, verify immediate reset values, release; returns at the
  // negedge just before the first active edge after release.
  task automatic do_reset();
    @(posedge refclk);
    #5 rst_n = 1'b0;
    #1;
    check("rst_pll_rst", pll_rst, 1);
    check("rst_sys_rst", sys_rst, 1);
    check("rst_ready",   ready,   0);
    check("rst_state",   state_o, 0);
    check("rst_retry",   retry_count, 0);
    check("rst_loss",    loss_count,  0);
    repeat (2) @(posedge refclk);
    #5 rst_n = 1'b1;
    @(negedge refclk);
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!ready && n < 200) begin
      @(negedge refclk);
      n++;
    end
    check(name, ready, 1);
  endtask

  initial begin
    int n;
    bit saw_wait;
    rst_n      = 1'b1;
    pll_locked = 1'b0;
    #2 rst_n   = 1'b0;

    // Nominal
    do_reset();
    n = 0;
    while (pll_rst && n < 100) begin
      n++;
      @(negedge refclk);
    end
    check("nom_pll_rst_len", n, P);
    repeat (2) @(negedge refclk);
    pll_locked = 1'b1;            // first sampled 3 edges after pll_rst fell
    n = 0;
    while (!ready && n < 100) begin
      @(negedge refclk);
      n++;
    end
    check("nom_lock_to_ready", n, 2 + S + 1);
    check("nom_sys_rst", sys_rst, 0);
    check("nom_retry", retry_count, 0);
    check("nom_loss", loss_count, 0);

    // Timeout retries with saturation
    pll_locked = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      repeat (P + T - 1) @(negedge refclk);
      check("tmo_pll_rst_low", pll_rst, 0);
      @(negedge refclk);
      check("tmo_pll_rst_high", pll_rst, 1);
      check("tmo_retry", retry_count, (i + 1 < SAT) ? i + 1 : SAT);
    end

    // Lock arrives on the final timeout cycle
    do_reset();
    n = 0;
    while (state_o != 2'd1 && n < 100) begin
      @(negedge refclk);
      n++;
    end
    repeat (T - 3) @(negedge refclk);
    pll_locked = 1'b1;
    repeat (2) @(negedge refclk);
    check("bnd_still_wait", state_o, 1);
    @(negedge refclk);
    check("bnd_stable", state_o, 2);
    check("bnd_retry", retry_count, 0);
    wait_ready("bnd_ready");

    // Glitch in STABLE
    pll_locked = 1'b0;
    do_reset();
    while (pll_rst && n < 100) @(negedge refclk);
    pll_locked = 1'b1;
    n = 0;
    while (state_o != 2'd2 && n < 100) begin
      @(negedge refclk);
      n++;
    end
    repeat (4) @(negedge refclk);
    pll_locked = 1'b0;
    @(negedge refclk);
    pll_locked = 1'b1;
    saw_wait = 1'b0;
    n = 0;
    while (!ready && n < 200) begin
      @(negedge refclk);
      if (state_o == 2'd1) saw_wait = 1'b1;
      n++;
    end
    check("glt_back_to_wait", saw_wait, 1);
    check("glt_ready", ready, 1);
    check("glt_retry", retry_count, 0);

    // Lock loss in RUN
    pll_locked = 1'b0;
    repeat (2) @(negedge refclk);
    check("loss_still_ready", ready, 1);
    @(negedge refclk);
    check("loss_sys_rst", sys_rst, 1);
    check("loss_ready", ready, 0);
    check("loss_pll_rst", pll_rst, 1);
    check("loss_count1", loss_count, 1);
    pll_locked = 1'b1;
    wait_ready("loss_relock");
    check("loss_count_hold", loss_count, 1);

    // Async reset mid-RUN, then mid-WAIT_LOCK
    do_reset();
    pll_locked = 1'b0;
    repeat (P + 5) @(negedge refclk);
    check("mid_wait_state", state_o, 1);
    do_reset();

    // Randomized lock behaviour
    for (int r = 0; r < 40; r++) begin
      int len;
      len = $urandom_range(1, 40);
      pll_locked = ($urandom_range(0, 3) != 0);
      repeat (len) @(negedge refclk);
      if ($urandom_range(0, 15) == 0) do_reset();
    end

    @(negedge refclk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
